// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, instruction decode and ID/EX register.
// Optional macro RF_WRITE_BYPASS_EN: same-cycle write-through from the W-stage port to the read ports.
module decode_stage #(
    parameter int               DPW   = 32,
    parameter int               ADW   = 5,
    parameter logic [DPW-1:0]   NOP_I = 32'h13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DPW-1:0]   instrF,
    input  logic [DPW-1:0]   PCF,
    input  logic [DPW-1:0]   PCPlus4F,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             flushE,
    input  logic             regwriteW,
    input  logic [ADW-1:0]   RdW,
    input  logic [DPW-1:0]   resultW,
    output logic [ADW-1:0]   Rs1D,
    output logic [ADW-1:0]   Rs2D,
    output logic [ADW-1:0]   Rs1E,
    output logic [ADW-1:0]   Rs2E,
    output logic [ADW-1:0]   RdE,
    output logic [DPW-1:0]   RD1E,
    output logic [DPW-1:0]   RD2E,
    output logic [DPW-1:0]   ImmExtE,
    output logic [DPW-1:0]   PCE,
    output logic [DPW-1:0]   PCPlus4E,
    output logic             regwriteE,
    output logic             resultsrcE,
    output logic             memwriteE,
    output logic             branchE,
    output logic             jumpE,
    output logic             linkE,
    output logic             alusrcE,
    output logic [3:0]       alucontrolE,
    output logic [2:0]       funct3E,
    output logic             illegalE
);

    typedef enum logic [3:0] {
        ADD_OP  = 4'd0,
        SUB_OP  = 4'd1,
        SLL_OP  = 4'd2,
        SLT_OP  = 4'd3,
        SLTU_OP = 4'd4,
        XOR_OP  = 4'd5,
        SRL_OP  = 4'd6,
        SRA_OP  = 4'd7,
        OR_OP   = 4'd8,
        AND_OP  = 4'd9
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [DPW-1:0] instrD_q, PCD_q, PCPlus4D_q;
    logic [DPW-1:0] rf_q [0:(1<<ADW)-1];

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            instrD_q   <= NOP_I;
            PCD_q      <= '0;
            PCPlus4D_q <= '0;
        end else if (!stallD) begin
            instrD_q   <= instrF;
            PCD_q      <= PCF;
            PCPlus4D_q <= PCPlus4F;
        end
    end

    // NOTE: the register file is cleared on rst so x1..x31 start at 0; that keeps it in flops rather than RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << ADW); i++) rf_q[i] <= '0;
        end else if (regwriteW && RdW != '0) begin
            rf_q[RdW] <= resultW;
        end
    end

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [ADW-1:0] rd;
    logic [DPW-1:0] rd1_d, rd2_d;

    assign opcode = instrD_q[6:0];
    assign funct3 = instrD_q[14:12];
    assign rd     = instrD_q[11:7];
    assign Rs1D   = instrD_q[19:15];
    assign Rs2D   = instrD_q[24:20];

    always_comb begin
        rd1_d = (Rs1D == '0) ? '0 : rf_q[Rs1D];
        rd2_d = (Rs2D == '0) ? '0 : rf_q[Rs2D];
`ifdef RF_WRITE_BYPASS_EN
        if (regwriteW && RdW != '0 && RdW == Rs1D) rd1_d = resultW;
        if (regwriteW && RdW != '0 && RdW == Rs2D) rd2_d = resultW;
`endif
    end

    logic [DPW-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    assign imm_i = {{(DPW-12){instrD_q[31]}}, instrD_q[31:20]};
    assign imm_s = {{(DPW-12){instrD_q[31]}}, instrD_q[31:25], instrD_q[11:7]};
    assign imm_b = {{(DPW-13){instrD_q[31]}}, instrD_q[31], instrD_q[7], instrD_q[30:25], instrD_q[11:8], 1'b0};
    assign imm_u = {instrD_q[31:12], 12'b0};
    assign imm_j = {{(DPW-21){instrD_q[31]}}, instrD_q[31], instrD_q[19:12], instrD_q[20], instrD_q[30:21], 1'b0};

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? SUB_OP : ADD_OP;
            3'b001:  alu_sel = SLL_OP;
            3'b010:  alu_sel = SLT_OP;
            3'b011:  alu_sel = SLTU_OP;
            3'b100:  alu_sel = XOR_OP;
            3'b101:  alu_sel = alt ? SRA_OP : SRL_OP;
            3'b110:  alu_sel = OR_OP;
            default: alu_sel = AND_OP;
        endcase
    endfunction

    logic           regwrite_d, resultsrc_d, memwrite_d, branch_d, jump_d, link_d, alusrc_d, illegal_d;
    alu_op_t        alu_d;
    logic [DPW-1:0] imm_d, opa_d;

    always_comb begin
        // NOTE: every decode output is defaulted first so no path through the case infers a latch.
        regwrite_d  = 1'b0;
        resultsrc_d = 1'b0;
        memwrite_d  = 1'b0;
        branch_d    = 1'b0;
        jump_d      = 1'b0;
        link_d      = 1'b0;
        alusrc_d    = 1'b0;
        illegal_d   = 1'b0;
        alu_d       = ADD_OP;
        imm_d       = '0;
        opa_d       = rd1_d;
        case (opcode)
            OPC_LUI:    begin regwrite_d = 1'b1; alusrc_d = 1'b1; imm_d = imm_u; opa_d = '0; end
            OPC_AUIPC:  begin regwrite_d = 1'b1; alusrc_d = 1'b1; imm_d = imm_u; opa_d = PCD_q; end
            // JAL feeds PC as operand A so the ALU produces the jump target.
            OPC_JAL:    begin regwrite_d = 1'b1; jump_d = 1'b1; link_d = 1'b1; alusrc_d = 1'b1;
                              imm_d = imm_j; opa_d = PCD_q; end
            OPC_JALR:   begin regwrite_d = 1'b1; jump_d = 1'b1; link_d = 1'b1; alusrc_d = 1'b1;
                              imm_d = imm_i; end
            OPC_BRANCH: begin branch_d = 1'b1; alu_d = SUB_OP; imm_d = imm_b; end
            OPC_LOAD:   begin regwrite_d = 1'b1; resultsrc_d = 1'b1; alusrc_d = 1'b1; imm_d = imm_i; end
            OPC_STORE:  begin memwrite_d = 1'b1; alusrc_d = 1'b1; imm_d = imm_s; end
            OPC_OPIMM:  begin regwrite_d = 1'b1; alusrc_d = 1'b1; imm_d = imm_i;
                              alu_d = alu_sel(funct3, instrD_q[30] && funct3 == 3'b101); end
            OPC_OP:     begin regwrite_d = 1'b1; alu_d = alu_sel(funct3, instrD_q[30]); end
            default:    illegal_d = 1'b1;
        endcase
        if (rd == '0) regwrite_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            regwriteE   <= 1'b0;
            resultsrcE  <= 1'b0;
            memwriteE   <= 1'b0;
            branchE     <= 1'b0;
            jumpE       <= 1'b0;
            linkE       <= 1'b0;
            alusrcE     <= 1'b0;
            alucontrolE <= '0;
            funct3E     <= '0;
            illegalE    <= 1'b0;
        end else begin
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= rd;
            RD1E        <= opa_d;
            RD2E        <= rd2_d;
            ImmExtE     <= imm_d;
            PCE         <= PCD_q;
            PCPlus4E    <= PCPlus4D_q;
            regwriteE   <= regwrite_d;
            resultsrcE  <= resultsrc_d;
            memwriteE   <= memwrite_d;
            branchE     <= branch_d;
            jumpE       <= jump_d;
            linkE       <= link_d;
            alusrcE     <= alusrc_d;
            alucontrolE <= alu_d;
            funct3E     <= funct3;
            illegalE    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a
// behavioural pipeline model (IF/ID record, register array, decode from the RV32I encoding rules).
module tb_decode_stage;

    localparam logic [31:0] NOP = 32'h13;
    localparam logic [3:0] ADD_OP = 4'd0, SUB_OP = 4'd1, SLL_OP = 4'd2, SLT_OP = 4'd3, SLTU_OP = 4'd4,
                           XOR_OP = 4'd5, SRL_OP = 4'd6, SRA_OP = 4'd7, OR_OP = 4'd8, AND_OP = 4'd9;

    logic        clk = 1'b0;
    logic        rst, stallD, flushD, flushE, regwriteW;
    logic [31:0] instrF, PCF, PCPlus4F, resultW;
    logic [4:0]  RdW, Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic        regwriteE, resultsrcE, memwriteE, branchE, jumpE, linkE, alusrcE, illegalE;
    logic [3:0]  alucontrolE;
    logic [2:0]  funct3E;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .instrF(instrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .regwriteE(regwriteE), .resultsrcE(resultsrcE), .memwriteE(memwriteE),
        .branchE(branchE), .jumpE(jumpE), .linkE(linkE), .alusrcE(alusrcE),
        .alucontrolE(alucontrolE), .funct3E(funct3E), .illegalE(illegalE)
    );

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic        regwrite, resultsrc, memwrite, branch, jump, link, alusrc, illegal;
        logic [3:0]  alu;
        logic [2:0]  f3;
    } ex_t;

    ex_t         m_e;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic [31:0] m_rf [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef RF_WRITE_BYPASS_EN
        if (regwriteW && RdW == a) return resultW;
`endif
        return m_rf[a];
    endfunction

    function automatic ex_t model_decode(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] pc4);
        ex_t        e;
        int         s, sgn;
        logic [3:0] alu_tab [8] = '{ADD_OP, SLL_OP, SLT_OP, SLTU_OP, XOR_OP, SRL_OP, OR_OP, AND_OP};
        e   = '0;
        s   = $signed(ins);
        sgn = s >>> 31;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.pc  = pc;
        e.pc4 = pc4;
        e.f3  = ins[14:12];
        e.rd1 = rf_read(e.rs1);
        e.rd2 = rf_read(e.rs2);
        case (ins[6:0])
            7'h37: begin e.regwrite = 1; e.alusrc = 1; e.imm = ins & 32'hFFFFF000; e.rd1 = 0; end
            7'h17: begin e.regwrite = 1; e.alusrc = 1; e.imm = ins & 32'hFFFFF000; e.rd1 = pc; end
            7'h6F: begin e.regwrite = 1; e.jump = 1; e.link = 1; e.alusrc = 1; e.rd1 = pc;
                         e.imm = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
            7'h67: begin e.regwrite = 1; e.jump = 1; e.link = 1; e.alusrc = 1; e.imm = s >>> 20; end
            7'h63: begin e.branch = 1; e.alu = SUB_OP;
                         e.imm = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
            7'h03: begin e.regwrite = 1; e.resultsrc = 1; e.alusrc = 1; e.imm = s >>> 20; end
            7'h23: begin e.memwrite = 1; e.alusrc = 1; e.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
            7'h13: begin e.regwrite = 1; e.alusrc = 1; e.imm = s >>> 20; e.alu = alu_tab[e.f3];
                         if (e.f3 == 3'd5 && ins[30]) e.alu = SRA_OP; end
            7'h33: begin e.regwrite = 1; e.alu = alu_tab[e.f3];
                         if (ins[30] && e.f3 == 3'd0) e.alu = SUB_OP;
                         if (ins[30] && e.f3 == 3'd5) e.alu = SRA_OP; end
            default: e.illegal = 1;
        endcase
        if (e.rd == 5'd0) e.regwrite = 0;
        return e;
    endfunction

    task automatic compare_all();
        check("Rs1D", 32'(Rs1D), 32'(m_instr[19:15]));
        check("Rs2D", 32'(Rs2D), 32'(m_instr[24:20]));
        check("Rs1E", 32'(Rs1E), 32'(m_e.rs1));
        check("Rs2E", 32'(Rs2E), 32'(m_e.rs2));
        check("RdE", 32'(RdE), 32'(m_e.rd));
        check("RD1E", RD1E, m_e.rd1);
        check("RD2E", RD2E, m_e.rd2);
        check("ImmExtE", ImmExtE, m_e.imm);
        check("PCE", PCE, m_e.pc);
        check("PCPlus4E", PCPlus4E, m_e.pc4);
        check("ctrl", {24'd0, regwriteE, resultsrcE, memwriteE, branchE, jumpE, linkE, alusrcE, illegalE},
              {24'd0, m_e.regwrite, m_e.resultsrc, m_e.memwrite, m_e.branch, m_e.jump, m_e.link, m_e.alusrc, m_e.illegal});
        check("alucontrolE", 32'(alucontrolE), 32'(m_e.alu));
        check("funct3E", 32'(funct3E), 32'(m_e.f3));
    endtask

    // One clock: drive inputs, advance the model, then sample just after the edge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic st, input logic fd,
                        input logic fe, input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                        input logic r);
        rst = r; instrF = ins; PCF = pc; PCPlus4F = pc + 32'd4;
        stallD = st; flushD = fd; flushE = fe; regwriteW = rw; RdW = rdw; resultW = res;
        if (r || fe) m_e = '0;
        else         m_e = model_decode(m_instr, m_pc, m_pc4);
        if (r || fd) begin
            m_instr = NOP; m_pc = 0; m_pc4 = 0;
        end else if (!st) begin
            m_instr = ins; m_pc = pc; m_pc4 = pc + 32'd4;
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (rw && rdw != 5'd0) begin
            m_rf[rdw] = res;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic run(input logic [31:0] ins, input logic [31:0] pc);
        step(ins, pc, 0, 0, 0, 0, 5'd0, 32'd0, 0);
    endtask

    initial begin
        logic [31:0] exp7, r, ins;
        logic [6:0]  op_tab [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h00};

        // Reset: every E output is zero.
        step(NOP, 0, 0, 0, 0, 0, 5'd0, 32'd0, 1);
        check("rst_RD1E", RD1E, 32'd0);
        check("rst_alusrcE", 32'(alusrcE), 32'd0);
        check("rst_PCPlus4E", PCPlus4E, 32'd0);
        // IF/ID holds the NOP after reset: addi x0,x0,0 reaches E.
        step(32'h00C00093, 32'h100, 1, 0, 0, 0, 5'd0, 32'd0, 0);
        check("nop_alusrcE", 32'(alusrcE), 32'd1);
        check("nop_regwriteE", 32'(regwriteE), 32'd0);

        // x1..x31 read 0 after reset.
        for (int i = 1; i <= 32; i++) begin
            ins = (i <= 31) ? ((32'(i) << 20) | (32'(i) << 15) | 32'h000000B3) : NOP;
            run(ins, 32'(i) * 4);
            if (i >= 2) begin
                check("rf_rst_RD1", RD1E, 32'd0);
                check("rf_rst_RD2", RD2E, 32'd0);
            end
        end

        // addi x5,x0,-3 at 0x40.
        run(32'hFFD00293, 32'h40);
        run(NOP, 32'h44);
        check("addi_RdE", 32'(RdE), 32'd5);
        check("addi_ImmExtE", ImmExtE, 32'hFFFFFFFD);
        check("addi_alusrcE", 32'(alusrcE), 32'd1);
        check("addi_regwriteE", 32'(regwriteE), 32'd1);
        check("addi_alucontrolE", 32'(alucontrolE), 32'(ADD_OP));
        check("addi_PCE", PCE, 32'h40);

        // Same-cycle write and read of x7.
        step(NOP, 32'h48, 0, 0, 0, 1, 5'd7, 32'h1111, 0);
        run(32'h00738433, 32'h4C);
        step(NOP, 32'h50, 0, 0, 0, 1, 5'd7, 32'hDEAD, 0);
`ifdef RF_WRITE_BYPASS_EN
        exp7 = 32'hDEAD;
`else
        exp7 = 32'h1111;
`endif
        check("byp_RD1E", RD1E, exp7);
        check("byp_RD2E", RD2E, exp7);
        check("byp_RdE", 32'(RdE), 32'd8);

        // Stall holds instrD for three cycles while instrF keeps changing.
        run(32'h06400493, 32'h60);
        for (int i = 0; i < 3; i++) begin
            step($urandom(), 32'h64 + 32'(i) * 4, 1, 0, 0, 0, 5'd0, 32'd0, 0);
            check("stall_RdE", 32'(RdE), 32'd9);
            check("stall_ImmExtE", ImmExtE, 32'd100);
            check("stall_PCE", PCE, 32'h60);
        end
        // Flush and stall together: flush wins.
        step(32'h00612423, 32'h70, 1, 1, 0, 0, 5'd0, 32'd0, 0);
        run(NOP, 32'h74);
        check("flushD_RdE", 32'(RdE), 32'd0);
        check("flushD_ImmExtE", ImmExtE, 32'd0);
        check("flushD_PCE", PCE, 32'd0);

        // flushE bubbles a store out; then the same store passes.
        run(32'h00612423, 32'h80);
        step(NOP, 32'h84, 0, 0, 1, 0, 5'd0, 32'd0, 0);
        check("flushE_memwriteE", 32'(memwriteE), 32'd0);
        check("flushE_regwriteE", 32'(regwriteE), 32'd0);
        run(32'h00612423, 32'h88);
        run(NOP, 32'h8C);
        check("sw_memwriteE", 32'(memwriteE), 32'd1);
        check("sw_ImmExtE", ImmExtE, 32'd8);

        // Writes to x0 are discarded.
        step(NOP, 32'h90, 0, 0, 0, 1, 5'd0, 32'h1234, 0);
        run(32'h000000B3, 32'h94);
        run(NOP, 32'h98);
        check("x0_RD1E", RD1E, 32'd0);

        // Unknown opcode and a backward branch.
        run(32'h0000007F, 32'hA0);
        run(32'hFE208CE3, 32'hA4);
        check("ill_illegalE", 32'(illegalE), 32'd1);
        check("ill_wr", {30'd0, regwriteE, memwriteE}, 32'd0);
        run(NOP, 32'hA8);
        check("beq_ImmExtE", ImmExtE, 32'hFFFFFFF8);
        check("beq_branchE", 32'(branchE), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            r   = $urandom();
            ins = {r[31:7], op_tab[$urandom_range(0, 9)]};
            if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom());
            step(ins, $urandom() & 32'hFFFFFFFC,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 0), 5'($urandom()), $urandom(),
                 ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
